// File: rtl/spi_pkg.sv
// Shared types and elaboration-time helpers for the SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    END   = 2'd2
  } state_t;

  // System clocks per sclk half period; integer division truncates.
  function automatic int half_period(input int clk_freq, input int spi_freq);
    return clk_freq / (2 * spi_freq);
  endfunction

  function automatic int cnt_width(input int half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/spi_master_clk_gen.sv
// Half-period tick generator: produces sclk plus leading/trailing edge strobes
// on the same clk edge that toggles sclk.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int HALF       = 250,
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 0
) (
  input  logic clk,
  input  logic arstn,
  input  logic run,
  input  logic shift_en,
  output logic sclk,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic last_edge
);

  localparam int CNT_W  = cnt_width(HALF);
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(HALF - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);
  localparam logic IDLE_LEVEL = (CPOL != 0);

  logic [CNT_W-1:0]  cnt_reg;
  logic [EDGE_W-1:0] edge_reg;
  logic              sclk_reg;

  // edge_reg holds the number of edges already emitted, so bit 0 clear means
  // the upcoming edge is a leading one.
  assign tick      = run && (cnt_reg == CNT_MAX);
  assign lead      = tick && shift_en && !edge_reg[0];
  assign trail     = tick && shift_en && edge_reg[0];
  assign last_edge = tick && shift_en && (edge_reg == EDGE_LAST);
  assign sclk      = sclk_reg;

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      cnt_reg  <= '0;
      edge_reg <= '0;
      sclk_reg <= IDLE_LEVEL;
    end else if (!run) begin
      cnt_reg  <= '0;
      edge_reg <= '0;
      sclk_reg <= IDLE_LEVEL;
    end else if (tick) begin
      cnt_reg  <= '0;
      edge_reg <= edge_reg + 1'b1;
      if (shift_en) begin
        sclk_reg <= ~sclk_reg;
      end
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-transaction SPI master: MSB-first shift with configurable CPOL/CPHA,
// one-cycle done pulse and a held received word.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SPI_FREQ   = 100_000,
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [DATA_WIDTH-1:0] data_send,
  input  logic                  spi_start,
  output logic                  sclk,
  output logic                  csn,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  spi_done,
  output logic [DATA_WIDTH-1:0] data_recv
);

  localparam int   HALF   = half_period(CLK_FREQ, SPI_FREQ);
  localparam logic PHASE1 = (CPHA != 0);
  // With CPHA=0 the MSB is already on mosi, so the first drive edge sends MSB-1.
  localparam int   DRIVE_BIT = PHASE1 ? DATA_WIDTH - 1 : DATA_WIDTH - 2;

  state_t state_reg, state_next;
  logic   run, shift_en, accept, finish;
  logic   tick, lead, trail, last_edge;
  logic   drive_edge, sample_edge;

  logic [DATA_WIDTH-1:0] tx_shift_reg, rx_shift_reg, data_recv_reg;
  logic                  csn_reg, mosi_reg, done_reg;

  spi_clk_gen #(
    .HALF       (HALF),
    .DATA_WIDTH (DATA_WIDTH),
    .CPOL       (CPOL)
  ) u_clk_gen (
    .clk       (clk),
    .arstn     (arstn),
    .run       (run),
    .shift_en  (shift_en),
    .sclk      (sclk),
    .tick      (tick),
    .lead      (lead),
    .trail     (trail),
    .last_edge (last_edge)
  );

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (spi_start) state_next = SHIFT;
      SHIFT:   if (last_edge) state_next = END;
      END:     if (tick)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    run      = 1'b0;
    shift_en = 1'b0;
    accept   = 1'b0;
    case (state_reg)
      IDLE:  accept = spi_start;
      SHIFT: begin
        run      = 1'b1;
        shift_en = 1'b1;
      end
      END:   run = 1'b1;
      default: ;
    endcase
  end

  // END spends one more half period with sclk parked before releasing csn.
  assign finish      = (state_reg == END) && tick;
  assign drive_edge  = PHASE1 ? lead : (trail && !last_edge);
  assign sample_edge = PHASE1 ? trail : lead;

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      data_recv_reg <= '0;
      csn_reg       <= 1'b1;
      mosi_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        tx_shift_reg <= data_send;
        rx_shift_reg <= '0;
        csn_reg      <= 1'b0;
        mosi_reg     <= PHASE1 ? 1'b0 : data_send[DATA_WIDTH-1];
      end
      if (drive_edge) begin
        mosi_reg     <= tx_shift_reg[DRIVE_BIT];
        tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
      end
      if (sample_edge) begin
        rx_shift_reg <= {rx_shift_reg[DATA_WIDTH-2:0], miso};
      end
      if (finish) begin
        csn_reg       <= 1'b1;
        mosi_reg      <= 1'b0;
        data_recv_reg <= rx_shift_reg;
        done_reg      <= 1'b1;
      end
    end
  end

  assign csn       = csn_reg;
  assign mosi      = mosi_reg;
  assign spi_done  = done_reg;
  assign data_recv = data_recv_reg;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: one default-rate instance in mode (0,1) plus three
// fast instances covering the remaining CPOL/CPHA modes.
module tb_spi_master;

  localparam int NDUT = 4;
  localparam int N    = 8;

  logic         clk = 1'b0;
  logic         arstn;
  logic [N-1:0] data_send_s [NDUT];
  logic         start_s     [NDUT];
  logic         sclk_s      [NDUT];
  logic         csn_s       [NDUT];
  logic         mosi_s      [NDUT];
  logic         miso_s      [NDUT];
  logic         done_s      [NDUT];
  logic [N-1:0] data_recv_s [NDUT];
  logic         loop_s      [NDUT];
  logic [N-1:0] slave_w     [NDUT];
  logic         slave_bit   [NDUT] = '{default: 1'b0};

  // Monitor state, written only by the monitor process.
  int           edges    [NDUT] = '{default: 0};
  int           gap_err  [NDUT] = '{default: 0};
  int           t_csn    [NDUT] = '{default: 0};
  int           t_edge   [NDUT] = '{default: 0};
  int           sbit     [NDUT] = '{default: 0};
  int           done_cnt [NDUT] = '{default: 0};
  int           wide_err [NDUT] = '{default: 0};
  logic [N-1:0] mosi_w   [NDUT] = '{default: '0};
  logic         prev_sclk[NDUT] = '{default: 1'b0};
  logic         prev_csn [NDUT] = '{default: 1'b1};
  logic         prev_done[NDUT] = '{default: 1'b0};

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           dut;
    logic [N-1:0] recv;
    logic [N-1:0] mosi;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int           dut;
    logic [N-1:0] data;
    logic [N-1:0] slave;
    logic         loop;
    logic [N-1:0] recv;
  } vec_t;
  vec_t vecs[8];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      spi_master #(
        .CLK_FREQ   (50_000_000),
        .SPI_FREQ   (gi == 0 ? 100_000 : 5_000_000),
        .DATA_WIDTH (N),
        .CPOL       ((gi == 2 || gi == 3) ? 1 : 0),
        .CPHA       ((gi == 0 || gi == 3) ? 1 : 0)
      ) u_dut (
        .clk       (clk),
        .arstn     (arstn),
        .data_send (data_send_s[gi]),
        .spi_start (start_s[gi]),
        .sclk      (sclk_s[gi]),
        .csn       (csn_s[gi]),
        .mosi      (mosi_s[gi]),
        .miso      (miso_s[gi]),
        .spi_done  (done_s[gi]),
        .data_recv (data_recv_s[gi])
      );
      assign miso_s[gi] = loop_s[gi] ? mosi_s[gi] : slave_bit[gi];
    end
  endgenerate

  function automatic logic cpol_of(input int d);
    return (d >= 2);
  endfunction

  function automatic logic cpha_of(input int d);
    return (d == 0 || d == 3);
  endfunction

  function automatic int half_of(input int d);
    return (d == 0) ? 250 : 5;
  endfunction

  // Bus monitor plus behavioural slave, evaluated away from the active clk edge.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (prev_csn[d] && !csn_s[d]) begin
        t_csn[d]   = cyc;
        edges[d]   = 0;
        gap_err[d] = 0;
        mosi_w[d]  = '0;
        sbit[d]    = 0;
        if (!cpha_of(d)) begin
          slave_bit[d] = slave_w[d][N-1];
          sbit[d]      = 1;
        end
      end
      if (sclk_s[d] !== prev_sclk[d]) begin
        if (cyc - ((edges[d] == 0) ? t_csn[d] : t_edge[d]) != half_of(d)) gap_err[d]++;
        t_edge[d] = cyc;
        edges[d]++;
        if ((sclk_s[d] != cpol_of(d)) != cpha_of(d)) begin
          mosi_w[d] = {mosi_w[d][N-2:0], mosi_s[d]};
        end else if (sbit[d] < N) begin
          slave_bit[d] = slave_w[d][N-1-sbit[d]];
          sbit[d]++;
        end
      end
      if (done_s[d] === 1'b1) begin
        done_cnt[d]++;
        if (prev_done[d]) wide_err[d]++;
      end
      prev_sclk[d] = sclk_s[d];
      prev_csn[d]  = csn_s[d];
      prev_done[d] = done_s[d];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic finish_txn(input int d, input int dc0);
    exp_t e;
    bit   got;
    int   limit;
    got   = 1'b0;
    limit = (2 * N + 1) * half_of(d) + 20;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_s[d] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    chk("done_seen", 32'(got), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("txn dut=%0d recv=0x%02h exp=0x%02h mosi=0x%02h exp_mosi=0x%02h",
               e.dut, data_recv_s[d], e.recv, mosi_w[d], e.mosi);
      chk("data_recv", 32'(data_recv_s[d]), 32'(e.recv));
      chk("mosi_bits", 32'(mosi_w[d]), 32'(e.mosi));
    end
    chk("sclk_edges", edges[d], 2 * N);
    chk("edge_spacing_errors", gap_err[d], 0);
    chk("done_time", cyc - t_csn[d], (2 * N + 1) * half_of(d));
    chk("done_count", done_cnt[d] - dc0, 1);
    chk("csn_end", 32'(csn_s[d]), 32'd1);
    chk("mosi_end", 32'(mosi_s[d]), 32'd0);
    chk("sclk_end", 32'(sclk_s[d]), 32'(cpol_of(d)));
  endtask

  task automatic run_txn(input int d, input logic [N-1:0] data, input logic [N-1:0] sw,
                         input logic lp, input logic [N-1:0] exp_recv);
    exp_t e;
    int   dc0;
    chk("idle_sclk", 32'(sclk_s[d]), 32'(cpol_of(d)));
    loop_s[d]      = lp;
    slave_w[d]     = sw;
    data_send_s[d] = data;
    start_s[d]     = 1'b1;
    e.dut  = d;
    e.recv = exp_recv;
    e.mosi = data;
    exp_q.push_back(e);
    dc0 = done_cnt[d];
    @(negedge clk);
    start_s[d]     = 1'b0;
    data_send_s[d] = ~data;
    #1;
    chk("accept_csn", 32'(csn_s[d]), 32'd0);
    chk("accept_mosi", 32'(mosi_s[d]), cpha_of(d) ? 32'd0 : 32'(data[N-1]));
    finish_txn(d, dc0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    exp_t e;
    int   dc0;
    int   tot;
    bit   got;

    vecs[0] = '{0, 8'hA5, 8'h5C, 1'b0, 8'h5C};
    vecs[1] = '{0, 8'h9A, 8'hC3, 1'b0, 8'hC3};
    vecs[2] = '{0, 8'h3C, 8'h00, 1'b1, 8'h3C};
    vecs[3] = '{1, 8'h3C, 8'h00, 1'b1, 8'h3C};
    vecs[4] = '{2, 8'h3C, 8'h00, 1'b1, 8'h3C};
    vecs[5] = '{3, 8'h3C, 8'h00, 1'b1, 8'h3C};
    vecs[6] = '{2, 8'h0F, 8'hF0, 1'b0, 8'hF0};
    vecs[7] = '{1, 8'h81, 8'h7E, 1'b0, 8'h7E};

    arstn = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      start_s[d]     = 1'b0;
      data_send_s[d] = '0;
      loop_s[d]      = 1'b1;
      slave_w[d]     = '0;
    end
    @(negedge clk);
    chk("reset_csn", 32'(csn_s[0]), 32'd1);
    chk("reset_sclk", 32'(sclk_s[0]), 32'd0);
    chk("reset_mosi", 32'(mosi_s[0]), 32'd0);
    chk("reset_done", 32'(done_s[0]), 32'd0);
    chk("reset_recv", 32'(data_recv_s[0]), 32'd0);
    chk("reset_sclk_cpol1", 32'(sclk_s[2]), 32'd1);
    arstn = 1'b0;
    @(negedge clk);

    // Consecutive table entries on the same instance start the cycle after done.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].dut, vecs[i].data, vecs[i].slave, vecs[i].loop, vecs[i].recv);
    end

    // spi_start held high, then re-pulsed, while a transfer is in flight.
    e.dut  = 1;
    e.recv = 8'h5A;
    e.mosi = 8'h5A;
    exp_q.push_back(e);
    dc0            = done_cnt[1];
    loop_s[1]      = 1'b1;
    data_send_s[1] = 8'h5A;
    start_s[1]     = 1'b1;
    @(negedge clk);
    data_send_s[1] = 8'hFF;
    repeat (20) @(negedge clk);
    start_s[1] = 1'b0;
    repeat (10) @(negedge clk);
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    finish_txn(1, dc0);
    repeat (100) @(negedge clk);
    #1;
    chk("held_done_count", done_cnt[1] - dc0, 1);
    chk("held_csn_idle", 32'(csn_s[1]), 32'd1);

    // Reset in the middle of a default-rate transfer, right after edge 7.
    dc0            = done_cnt[0];
    loop_s[0]      = 1'b1;
    data_send_s[0] = 8'h77;
    start_s[0]     = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    #1;
    got = 1'b0;
    for (int i = 0; i < 8 * 250 + 20; i++) begin
      if (edges[0] >= 7) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("rst_reach_edge7", 32'(got), 32'd1);
    chk("rst_pre_sclk", 32'(sclk_s[0]), 32'd1);
    arstn = 1'b1;
    #1;
    chk("rst_async_csn", 32'(csn_s[0]), 32'd1);
    chk("rst_async_sclk", 32'(sclk_s[0]), 32'd0);
    chk("rst_async_mosi", 32'(mosi_s[0]), 32'd0);
    chk("rst_async_recv", 32'(data_recv_s[0]), 32'd0);
    chk("rst_async_recv_d3", 32'(data_recv_s[3]), 32'd0);
    @(negedge clk);
    arstn = 1'b0;
    repeat (3000) @(negedge clk);
    #1;
    chk("rst_no_done", done_cnt[0] - dc0, 0);
    chk("rst_recv_held", 32'(data_recv_s[0]), 32'd0);
    chk("rst_csn_idle", 32'(csn_s[0]), 32'd1);

    tot = 0;
    for (int d = 0; d < NDUT; d++) tot += wide_err[d];
    chk("done_pulse_width", tot, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
